motor_pwm_ctrl: RTL and testbench

Parametrised N-channel H-bridge PWM motor controller, generalising the two-channel speed controller. Each channel takes a target duty level and a direction, slews its applied duty toward the target at a fixed rate, and brings the motor through zero with a dead time on every reversal. It sits between the switch/button inputs in the top level and the motor driver pins.

---
 rtl/motor_pwm_ctrl_pkg.sv | 15 +
 rtl/motor_pwm_ctrl_if.sv | 30 +++
 rtl/motor_pwm_channel.sv | 168 ++++++++++++++++
 rtl/motor_pwm_ctrl.sv | 75 +++++++
 tb/tb_motor_pwm_ctrl.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/motor_pwm_ctrl_pkg.sv
// motor_pkg: shared types and constants for the H-bridge PWM motor controller.
//   ch_state_t : per-channel reversal state (RUN / DECEL / DEAD)
//   DIR_FWD/DIR_REV : direction encoding of dir_in and the latched direction
package motor_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DECEL = 2'd1,
        DEAD  = 2'd2
    } ch_state_t;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

endpackage

// File: rtl/motor_pwm_ctrl_if.sv
// motor_pwm_ctrl_if: bundles the per-channel command inputs and the driver
// outputs of motor_pwm_ctrl.
//   level_in        : NUM_CH*DUTY_W target duty, channel i at [i*DUTY_W +: DUTY_W]
//   dir_in          : requested direction per channel (0 fwd, 1 rev)
//   brake_in        : brake request per channel (MOTOR_BRAKE_EN builds only)
//   pwm_out         : [2i] forward leg, [2i+1] reverse leg of channel i
//   at_target_out   : channel running at its target duty
//   period_tick_out : pulse on the last clock of each PWM period
// master = command source, slave = the controller.
interface motor_pwm_ctrl_if #(
    parameter int NUM_CH = 2,
    parameter int DUTY_W = 8
);
    logic [NUM_CH*DUTY_W-1:0] level_in;
    logic [NUM_CH-1:0]        dir_in;
    logic [NUM_CH-1:0]        brake_in;
    logic [2*NUM_CH-1:0]      pwm_out;
    logic [NUM_CH-1:0]        at_target_out;
    logic                     period_tick_out;

    modport master (
        output level_in, dir_in, brake_in,
        input  pwm_out, at_target_out, period_tick_out
    );

    modport slave (
        input  level_in, dir_in, brake_in,
        output pwm_out, at_target_out, period_tick_out
    );
endinterface

// File: rtl/motor_pwm_channel.sv
// motor_pwm_channel: one H-bridge channel. Slews the applied duty toward the
// target once per PWM period, walks reversals through DECEL and DEAD, and
// produces the registered leg pair from the shared counter.
//   clk_i, rst_n_i : clock, async active-low reset
//   cnt_i, tick_i  : shared PWM counter and end-of-period tick
//   level_i, dir_i : target duty and requested direction
//   brake_i        : brake request (present only with MOTOR_BRAKE_EN)
//   pwm_o          : [0] forward leg, [1] reverse leg
//   at_target_o    : RUN with applied duty equal to target
// Optional feature macro: MOTOR_BRAKE_EN.
module motor_pwm_channel
    import motor_pkg::*;
#(
    parameter int DUTY_W       = 8,
    parameter int RAMP_STEP    = 16,
    parameter int DEAD_PERIODS = 2
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [DUTY_W-1:0] cnt_i,
    input  logic              tick_i,
    input  logic [DUTY_W-1:0] level_i,
    input  logic              dir_i,
`ifdef MOTOR_BRAKE_EN
    input  logic              brake_i,
`endif
    output logic [1:0]        pwm_o,
    output logic              at_target_o
);

    localparam int DMAX = (1 << DUTY_W) - 1;
    localparam int STEP = (RAMP_STEP > DMAX) ? DMAX : RAMP_STEP;
    localparam int DC_W = $clog2(DEAD_PERIODS + 1);

    localparam logic [DUTY_W:0]   STEP_X = (DUTY_W + 1)'(STEP);
    localparam logic [DUTY_W-1:0] STEP_N = DUTY_W'(STEP);

    ch_state_t         state_q, state_d;
    logic [DUTY_W-1:0] cur_q, cur_d;
    logic              dir_q, dir_d;
    logic [DC_W-1:0]   dead_q, dead_d;
    logic              at_q, at_d;
    logic [1:0]        pwm_q, pwm_d;
`ifdef MOTOR_BRAKE_EN
    // Set while braking; the first tick after release re-latches dir_i.
    logic              brk_q, brk_d;
`endif

    logic [DUTY_W-1:0] eff_tgt, ramp_nxt;
    logic [DUTY_W:0]   cur_x, tgt_x, up_x, dn_lim_x;

    // Ramp in DUTY_W+1 bits so cur+STEP cannot wrap past full scale.
    always_comb begin
        eff_tgt  = (state_q == DECEL) ? '0 : level_i;
        cur_x    = {1'b0, cur_q};
        tgt_x    = {1'b0, eff_tgt};
        up_x     = cur_x + STEP_X;
        dn_lim_x = tgt_x + STEP_X;
        if (RAMP_STEP == 0)
            ramp_nxt = eff_tgt;
        else if (cur_x < tgt_x)
            ramp_nxt = (up_x > tgt_x) ? eff_tgt : up_x[DUTY_W-1:0];
        else if (cur_x > tgt_x)
            ramp_nxt = (cur_x > dn_lim_x) ? (cur_q - STEP_N) : eff_tgt;
        else
            ramp_nxt = cur_q;
    end

    // Next state. On the tick that first sees a reversal the applied duty is
    // held: the flip wins over any simultaneous level change.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        dir_d   = dir_q;
        dead_d  = dead_q;
        at_d    = at_q;
`ifdef MOTOR_BRAKE_EN
        brk_d   = brk_q;
        if (brake_i) begin
            state_d = RUN;
            cur_d   = '0;
            dead_d  = '0;
            at_d    = 1'b0;
            brk_d   = 1'b1;
        end else if (tick_i && brk_q) begin
            brk_d = 1'b0;
            dir_d = dir_i;
            cur_d = ramp_nxt;
            at_d  = (ramp_nxt == level_i);
        end else
`endif
        if (tick_i) begin
            unique case (state_q)
                RUN: begin
                    if (dir_i != dir_q) begin
                        if (cur_q == '0) begin
                            state_d = DEAD;
                            dead_d  = DC_W'(DEAD_PERIODS);
                        end else begin
                            state_d = DECEL;
                        end
                    end else begin
                        cur_d = ramp_nxt;
                    end
                end
                DECEL: begin
                    cur_d = ramp_nxt;
                    if (dir_i == dir_q) begin
                        state_d = RUN;
                    end else if (ramp_nxt == '0) begin
                        state_d = DEAD;
                        dead_d  = DC_W'(DEAD_PERIODS);
                    end
                end
                DEAD: begin
                    dead_d = dead_q - 1'b1;
                    if (dead_q == DC_W'(1)) begin
                        state_d = RUN;
                        dir_d   = dir_i;
                        cur_d   = '0;
                    end
                end
                default: state_d = RUN;
            endcase
            at_d = (state_d == RUN) && (cur_d == level_i);
        end
    end

    // Leg mux: compare drives only the leg of the latched direction.
    always_comb begin
        pwm_d = 2'b00;
        if (state_q != DEAD) begin
            if (dir_q == DIR_REV) pwm_d[1] = (cnt_i < cur_q);
            else                  pwm_d[0] = (cnt_i < cur_q);
        end
`ifdef MOTOR_BRAKE_EN
        if (brake_i) pwm_d = 2'b11;
`endif
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= RUN;
            cur_q   <= '0;
            dir_q   <= DIR_FWD;
            dead_q  <= '0;
            at_q    <= 1'b0;
            pwm_q   <= 2'b00;
`ifdef MOTOR_BRAKE_EN
            brk_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            dir_q   <= dir_d;
            dead_q  <= dead_d;
            at_q    <= at_d;
            pwm_q   <= pwm_d;
`ifdef MOTOR_BRAKE_EN
            brk_q   <= brk_d;
`endif
        end
    end

    assign pwm_o       = pwm_q;
    assign at_target_o = at_q;

endmodule

// File: rtl/motor_pwm_ctrl.sv
// motor_pwm_ctrl: N-channel H-bridge PWM controller. Holds the shared
// prescaler and PWM counter and instantiates one motor_pwm_channel per motor.
//   clk_in, rst_n_in : clock, async active-low reset
//   bus (slave)      : level_in/dir_in/brake_in in, pwm_out/at_target_out/
//                      period_tick_out out
// Optional feature macro: MOTOR_BRAKE_EN (brake_in drives both legs high).
module motor_pwm_ctrl
    import motor_pkg::*;
#(
    parameter int NUM_CH       = 2,
    parameter int DUTY_W       = 8,
    parameter int PRESCALE     = 1,
    parameter int RAMP_STEP    = 16,
    parameter int DEAD_PERIODS = 2
) (
    input  logic           clk_in,
    input  logic           rst_n_in,
    motor_pwm_ctrl_if.slave bus
);

    localparam int CNT_MAX = (1 << DUTY_W) - 2;
    localparam int PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PS_W-1:0]   presc_q, presc_d;
    logic [DUTY_W-1:0] cnt_q, cnt_d;
    logic              presc_wrap, tick;

    logic [NUM_CH-1:0][1:0] pwm_w;
    logic [NUM_CH-1:0]      at_w;

    assign presc_wrap = (presc_q == PS_W'(PRESCALE - 1));
    assign tick       = presc_wrap && (cnt_q == DUTY_W'(CNT_MAX));

    always_comb begin
        presc_d = presc_wrap ? '0 : presc_q + 1'b1;
        cnt_d   = cnt_q;
        if (presc_wrap)
            cnt_d = (cnt_q == DUTY_W'(CNT_MAX)) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            presc_q <= '0;
            cnt_q   <= '0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        motor_pwm_channel #(
            .DUTY_W      (DUTY_W),
            .RAMP_STEP   (RAMP_STEP),
            .DEAD_PERIODS(DEAD_PERIODS)
        ) u_ch (
            .clk_i      (clk_in),
            .rst_n_i    (rst_n_in),
            .cnt_i      (cnt_q),
            .tick_i     (tick),
            .level_i    (bus.level_in[g*DUTY_W +: DUTY_W]),
            .dir_i      (bus.dir_in[g]),
`ifdef MOTOR_BRAKE_EN
            .brake_i    (bus.brake_in[g]),
`endif
            .pwm_o      (pwm_w[g]),
            .at_target_o(at_w[g])
        );
    end

    assign bus.pwm_out         = pwm_w;
    assign bus.at_target_out   = at_w;
    assign bus.period_tick_out = tick;

endmodule

// File: tb/tb_motor_pwm_ctrl.sv
// tb_motor_pwm_ctrl: table of settle-and-measure vectors, hand sequences for
// async reset and brake, and a randomized phase checked every cycle against
// a period-level behavioural model. Honors MOTOR_BRAKE_EN if defined.
module tb_motor_pwm_ctrl;

    localparam int NC   = 2;
    localparam int DW   = 8;
    localparam int PS   = 1;
    localparam int STEP = 16;
    localparam int DP   = 2;
    localparam int PLEN = (1 << DW) - 1;
`ifdef MOTOR_BRAKE_EN
    localparam bit BRK = 1'b1;
`else
    localparam bit BRK = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    motor_pwm_ctrl_if #(.NUM_CH(NC), .DUTY_W(DW)) bus ();

    motor_pwm_ctrl #(
        .NUM_CH(NC), .DUTY_W(DW), .PRESCALE(PS),
        .RAMP_STEP(STEP), .DEAD_PERIODS(DP)
    ) dut (
        .clk_in  (clk),
        .rst_n_in(rst_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int  m_ps = 0, m_cnt = 0;
    int  m_cur[NC], m_dead[NC];
    bit  m_dir[NC], m_rev[NC], m_rel[NC];
    logic [2*NC-1:0] m_pwm = '0;
    logic [NC-1:0]   m_at  = '0;
    logic            m_tick = 1'b0;

    function automatic int ramp(input int c, input int t);
        if (STEP == 0) return t;
        if (c < t) return (c + STEP > t) ? t : c + STEP;
        if (c > t) return (c - STEP < t) ? t : c - STEP;
        return c;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ps = 0; m_cnt = 0; m_pwm = '0; m_at = '0; m_tick = 1'b0;
            for (int c = 0; c < NC; c++) begin
                m_cur[c] = 0; m_dead[c] = 0; m_dir[c] = 0; m_rev[c] = 0; m_rel[c] = 0;
            end
        end else begin
            bit tk;
            tk = (m_ps == PS - 1) && (m_cnt == PLEN - 1);
            for (int c = 0; c < NC; c++) begin
                int lv; bit d; bit on;
                lv = int'(bus.level_in[c*DW +: DW]);
                d  = bus.dir_in[c];
                on = (m_dead[c] == 0) && (m_cnt < m_cur[c]);
                m_pwm[2*c]   = on && !m_dir[c];
                m_pwm[2*c+1] = on && m_dir[c];
                if (BRK && bus.brake_in[c]) begin
                    m_pwm[2*c +: 2] = 2'b11;
                    m_cur[c] = 0; m_dead[c] = 0; m_rev[c] = 0; m_rel[c] = 1; m_at[c] = 0;
                end else if (tk) begin
                    if (m_rel[c]) begin
                        m_rel[c] = 0; m_dir[c] = d; m_cur[c] = ramp(m_cur[c], lv);
                    end else if (m_dead[c] > 0) begin
                        m_dead[c]--;
                        if (m_dead[c] == 0) begin m_dir[c] = d; m_cur[c] = 0; end
                    end else if (m_rev[c]) begin
                        m_cur[c] = ramp(m_cur[c], 0);
                        if (d == m_dir[c]) m_rev[c] = 0;
                        else if (m_cur[c] == 0) begin m_rev[c] = 0; m_dead[c] = DP; end
                    end else if (d != m_dir[c]) begin
                        if (m_cur[c] == 0) m_dead[c] = DP;
                        else m_rev[c] = 1;
                    end else begin
                        m_cur[c] = ramp(m_cur[c], lv);
                    end
                    m_at[c] = (m_dead[c] == 0) && !m_rev[c] && (m_cur[c] == lv);
                end
            end
            if (m_ps == PS - 1) begin
                m_ps = 0;
                m_cnt = (m_cnt == PLEN - 1) ? 0 : m_cnt + 1;
            end else begin
                m_ps++;
            end
            m_tick = (m_ps == PS - 1) && (m_cnt == PLEN - 1);
        end
    end

    // Every-cycle comparison against the model, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            n_chk++;
            if ({bus.pwm_out, bus.at_target_out, bus.period_tick_out} !== {m_pwm, m_at, m_tick}) begin
                n_fail++;
                if (n_fail < 20)
                    $display("FAIL cycle_model t=%0t: got pwm=%b at=%b tick=%b, expected pwm=%b at=%b tick=%b",
                             $time, bus.pwm_out, bus.at_target_out, bus.period_tick_out, m_pwm, m_at, m_tick);
            end
            if (!BRK) begin
                n_chk++;
                for (int c = 0; c < NC; c++)
                    if (bus.pwm_out[2*c +: 2] === 2'b11) begin
                        n_fail++;
                        $display("FAIL legs_exclusive ch%0d t=%0t: got both legs high, expected at most one", c, $time);
                    end
            end
        end
    end

    // ---------------- directed helpers ----------------
    typedef struct {
        int l0; int d0; int l1; int d1; int n;
        int h0; int h1; int h2; int h3;
        int a0; int a1;
    } vec_t;

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait_tick();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (bus.period_tick_out !== 1'b1 && k < 2 * PLEN * PS + 10);
        if (bus.period_tick_out !== 1'b1) check("tick_timeout", 0, 1);
    endtask

    // Entered on the falling edge of a tick cycle: inputs land on that tick.
    // After the n-th tick, the next full period's high counts are taken over
    // counter values 0..253 (so full scale reads 254), ending on the next
    // tick cycle, which is where the following vector starts.
    task automatic run_vec(input vec_t v, input string nm);
        int hi[4];
        int ex[4];
        bus.level_in = {DW'(v.l1), DW'(v.l0)};
        bus.dir_in   = {1'(v.d1), 1'(v.d0)};
        for (int i = 1; i < v.n; i++) wait_tick();
        @(negedge clk);
        hi = '{0, 0, 0, 0};
        repeat (PLEN - 1) begin
            @(negedge clk);
            for (int b = 0; b < 4; b++) hi[b] += int'(bus.pwm_out[b]);
        end
        ex = '{v.h0, v.h1, v.h2, v.h3};
        for (int b = 0; b < 4; b++) check($sformatf("%s_hi%0d", nm, b), hi[b], ex[b]);
        check({nm, "_at0"}, int'(bus.at_target_out[0]), v.a0);
        check({nm, "_at1"}, int'(bus.at_target_out[1]), v.a1);
        check({nm, "_period"}, int'(bus.period_tick_out), 1);
    endtask

    vec_t tbl[20];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        //          l0  d0 l1  d1  n   h0   h1  h2   h3 a0 a1
        tbl[0]  = '{128, 0,   0, 0,  7, 112,   0,   0, 0, 0, 1};
        tbl[1]  = '{128, 0,   0, 0,  1, 128,   0,   0, 0, 1, 1};
        tbl[2]  = '{128, 0, 255, 0, 16, 128,   0, 254, 0, 1, 1};
        tbl[3]  = '{128, 0,   0, 0,  1, 128,   0, 239, 0, 1, 0};
        tbl[4]  = '{128, 0,   0, 0, 15, 128,   0,   0, 0, 1, 1};
        tbl[5]  = '{128, 1,   0, 0,  1, 128,   0,   0, 0, 0, 1};
        tbl[6]  = '{128, 1,   0, 0,  7,  16,   0,   0, 0, 0, 1};
        tbl[7]  = '{128, 1,   0, 0,  1,   0,   0,   0, 0, 0, 1};
        tbl[8]  = '{128, 1,   0, 0,  1,   0,   0,   0, 0, 0, 1};
        tbl[9]  = '{128, 1,   0, 0,  1,   0,   0,   0, 0, 0, 1};
        tbl[10] = '{128, 1,   0, 0,  1,   0,  16,   0, 0, 0, 1};
        tbl[11] = '{128, 1,   0, 0,  7,   0, 128,   0, 0, 1, 1};
        tbl[12] = '{ 64, 0,   0, 0,  1,   0, 128,   0, 0, 0, 1};
        tbl[13] = '{ 64, 0,   0, 0,  8,   0,   0,   0, 0, 0, 1};
        tbl[14] = '{ 64, 0,   0, 0,  2,   0,   0,   0, 0, 0, 1};
        tbl[15] = '{ 64, 0,   0, 0,  4,  64,   0,   0, 0, 1, 1};
        tbl[16] = '{ 64, 1,   0, 1,  1,  64,   0,   0, 0, 0, 0};
        tbl[17] = '{ 64, 1,   0, 1,  2,  32,   0,   0, 0, 0, 1};
        tbl[18] = '{ 64, 0,   0, 1,  1,  16,   0,   0, 0, 0, 1};
        tbl[19] = '{ 64, 0,   0, 1,  3,  64,   0,   0, 0, 1, 1};

        // Reset held with random inputs.
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.level_in = 16'($urandom);
            bus.dir_in   = 2'($urandom);
            bus.brake_in = 2'($urandom);
            @(negedge clk);
            check($sformatf("reset_pwm%0d", i), int'(bus.pwm_out), 0);
            check($sformatf("reset_at%0d", i), int'(bus.at_target_out), 0);
            check($sformatf("reset_tick%0d", i), int'(bus.period_tick_out), 0);
        end
        bus.level_in = '0; bus.dir_in = '0; bus.brake_in = '0;
        rst_n = 1'b1;
        repeat (2 * PLEN * PS) @(negedge clk);

        wait_tick();
        for (int i = 0; i < 20; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Async reset mid-ramp, between clock edges.
        v = '{200, 0, 0, 0, 3, 112, 0, 0, 0, 0, 1};
        run_vec(v, "pre_reset");
        repeat (3) @(negedge clk);
        check("pre_reset_leg_high", int'(bus.pwm_out[0]), 1);
        #2 rst_n = 1'b0;
        #1 check("async_reset_pwm", int'(bus.pwm_out), 0);
        check("async_reset_at", int'(bus.at_target_out), 0);
        bus.level_in = '0; bus.dir_in = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_tick();
        v = '{128, 0, 0, 0, 1, 16, 0, 0, 0, 0, 1};
        run_vec(v, "post_reset_ramp");
        v = '{128, 0, 0, 0, 7, 128, 0, 0, 0, 1, 1};
        run_vec(v, "post_reset_full");

        // Brake on channel 0 at duty 128.
        repeat (2) @(negedge clk);
        bus.brake_in = 2'b01;
        @(negedge clk);
        check("brake_legs", int'(bus.pwm_out[1:0]), BRK ? 3 : 1);
        check("brake_at", int'(bus.at_target_out[0]), BRK ? 0 : 1);
        repeat (300) @(negedge clk);
        bus.brake_in = 2'b00;
        wait_tick();
        v = '{128, 0, 0, 0, 1, BRK ? 16 : 128, 0, 0, 0, BRK ? 0 : 1, 1};
        run_vec(v, "brake_release");

        // Randomized phase: the per-cycle model does the checking.
        for (int i = 0; i < 30; i++) begin
            int r;
            @(negedge clk);
            r = int'($urandom_range(0, 3));
            bus.level_in[7:0]  = (r == 0) ? 8'd0 : (r == 1) ? 8'd255 : 8'($urandom);
            bus.level_in[15:8] = 8'($urandom);
            bus.dir_in         = 2'($urandom);
            bus.brake_in       = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00;
            repeat ($urandom_range(50, 1500)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
